// File: rtl/asterix_pkg.sv
// Shared definitions for the Asterix datapath: stack op encodings and word width.
// Used by the data stack, the ALU and the Y/T multiplexers.
package asterix_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OP_HOLD    = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

endpackage

// File: rtl/data_stack_if.sv
// Operation/status bundle between the sequencer (master) and the data stack (slave).
interface data_stack_if
    import asterix_pkg::*;
#(
    parameter int DATA_W = asterix_pkg::DATA_W,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH + 2);

    op_e               op;
    logic [DATA_W-1:0] din;
    logic              clr_err;
    logic [DATA_W-1:0] next_out;
    logic [CW-1:0]     count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output op, din, clr_err,
        input  next_out, count, empty, full, overflow, underflow
    );

    modport slave (
        input  op, din, clr_err,
        output next_out, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_ram.sv
// Spill storage below NEXT: one synchronous write port, one combinational read port
// so that POP can refill NEXT in the same cycle.
module stack_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/data_stack.sv
// Data stack: NEXT register plus DEPTH-entry spill RAM, with element count,
// full/empty decode and sticky overflow/underflow flags.
module data_stack
    import asterix_pkg::*;
#(
    parameter int DATA_W = asterix_pkg::DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    data_stack_if.slave     bus
);
    localparam int CW  = $clog2(DEPTH + 2);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH + 1);

    logic [DATA_W-1:0] next_reg;
    logic [CW-1:0]     count_reg;
    logic [SPW-1:0]    sp_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    logic              is_empty;
    logic              is_full;
    logic              has_spill;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [AW-1:0]     ram_waddr;
    logic [AW-1:0]     ram_raddr;

    assign is_empty  = (count_reg == '0);
    assign is_full   = (count_reg == CNT_FULL);
    // At least one element lives in RAM beneath NEXT.
    assign has_spill = (count_reg >= CW'(2));

    assign ram_we    = !rst && (bus.op == OP_PUSH) && !is_full && !is_empty;
    assign ram_waddr = AW'(sp_reg);
    assign ram_raddr = AW'(sp_reg - 1'b1);

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (next_reg),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            next_reg      <= '0;
            count_reg     <= '0;
            sp_reg        <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            // Clear first so an error raised in the same cycle overrides it.
            if (bus.clr_err) begin
                overflow_reg  <= 1'b0;
                underflow_reg <= 1'b0;
            end
            case (bus.op)
                OP_PUSH: begin
                    if (is_full) begin
                        overflow_reg <= 1'b1;
                    end else begin
                        next_reg  <= bus.din;
                        count_reg <= count_reg + 1'b1;
                        if (!is_empty) begin
                            sp_reg <= sp_reg + 1'b1;
                        end
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        underflow_reg <= 1'b1;
                    end else begin
                        next_reg  <= has_spill ? ram_rdata : '0;
                        count_reg <= count_reg - 1'b1;
                        if (has_spill) begin
                            sp_reg <= sp_reg - 1'b1;
                        end
                    end
                end
                OP_REPLACE: begin
                    next_reg <= bus.din;
                    if (is_empty) begin
                        count_reg <= CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.next_out  = next_reg;
    assign bus.count     = count_reg;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack: hand-computed vectors plus a LIFO reference
// model for the alternating PUSH/POP run.
module tb_data_stack;
    import asterix_pkg::*;

    localparam int DW = 16;
    localparam int DP = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    data_stack_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    data_stack #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply one op for one edge, then return 1 time unit after that edge.
    task automatic step(input op_e o, input logic [DW-1:0] d, input logic c, input logic r);
        @(negedge clk);
        bus.op      = o;
        bus.din     = d;
        bus.clr_err = c;
        rst         = r;
        @(posedge clk);
        #1;
        bus.op      = OP_HOLD;
        bus.clr_err = 1'b0;
        rst         = 1'b0;
        $display("txn op=%s din=%h clr=%b rst=%b -> next=%h count=%0d e=%b f=%b ovf=%b unf=%b",
                 o.name(), d, c, r, bus.next_out, bus.count, bus.empty, bus.full,
                 bus.overflow, bus.underflow);
    endtask

    task automatic check_all(input string tag, input logic [DW-1:0] nx, input int cnt,
                             input logic ovf, input logic unf);
        check({tag, ".next"},  32'(bus.next_out), 32'(nx));
        check({tag, ".count"}, 32'(bus.count), 32'(cnt));
        check({tag, ".empty"}, 32'(bus.empty), 32'(cnt == 0));
        check({tag, ".full"},  32'(bus.full), 32'(cnt == DP + 1));
        check({tag, ".ovf"},   32'(bus.overflow), 32'(ovf));
        check({tag, ".unf"},   32'(bus.underflow), 32'(unf));
    endtask

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] v;

    initial begin
        bus.op      = OP_HOLD;
        bus.din     = '0;
        bus.clr_err = 1'b0;

        // Reset state
        step(OP_HOLD, 16'h0, 1'b0, 1'b1);
        check_all("reset", 16'h0000, 0, 1'b0, 1'b0);

        // Basic push/pop
        step(OP_PUSH, 16'h1111, 1'b0, 1'b0);
        step(OP_PUSH, 16'h2222, 1'b0, 1'b0);
        step(OP_PUSH, 16'h3333, 1'b0, 1'b0);
        check_all("push3", 16'h3333, 3, 1'b0, 1'b0);
        step(OP_HOLD, 16'hDEAD, 1'b0, 1'b0);
        check_all("hold", 16'h3333, 3, 1'b0, 1'b0);
        step(OP_POP, 16'h0, 1'b0, 1'b0);
        check_all("pop1", 16'h2222, 2, 1'b0, 1'b0);
        step(OP_POP, 16'h0, 1'b0, 1'b0);
        check_all("pop2", 16'h1111, 1, 1'b0, 1'b0);
        step(OP_POP, 16'h0, 1'b0, 1'b0);
        check_all("pop3", 16'h0000, 0, 1'b0, 1'b0);

        // Fill to full, overflow, then drain and verify every stored word
        for (int i = 1; i <= DP + 1; i++) begin
            step(OP_PUSH, 16'(i), 1'b0, 1'b0);
        end
        check_all("fill", 16'h0011, DP + 1, 1'b0, 1'b0);
        step(OP_PUSH, 16'hFFFF, 1'b0, 1'b0);
        check_all("ovf", 16'h0011, DP + 1, 1'b1, 1'b0);
        for (int i = DP; i >= 0; i--) begin
            step(OP_POP, 16'h0, 1'b0, 1'b0);
            check("drain.next", 32'(bus.next_out), 32'(i));
            check("drain.count", 32'(bus.count), 32'(i));
        end
        check("drain.ovf", 32'(bus.overflow), 32'(1));
        step(OP_HOLD, 16'h0, 1'b1, 1'b0);
        check_all("clr_ovf", 16'h0000, 0, 1'b0, 1'b0);

        // Underflow and clearing it
        step(OP_POP, 16'h0, 1'b0, 1'b0);
        check_all("unf", 16'h0000, 0, 1'b0, 1'b1);
        step(OP_HOLD, 16'h0, 1'b1, 1'b0);
        check_all("clr_unf", 16'h0000, 0, 1'b0, 1'b0);
        // Error event in the same cycle as clr_err: set wins
        step(OP_POP, 16'h0, 1'b1, 1'b0);
        check_all("set_wins", 16'h0000, 0, 1'b0, 1'b1);
        step(OP_HOLD, 16'h0, 1'b1, 1'b0);

        // Replace
        step(OP_PUSH, 16'hAAAA, 1'b0, 1'b0);
        step(OP_REPLACE, 16'h5555, 1'b0, 1'b0);
        check_all("repl", 16'h5555, 1, 1'b0, 1'b0);
        step(OP_POP, 16'h0, 1'b0, 1'b0);
        check_all("repl_pop", 16'h0000, 0, 1'b0, 1'b0);
        step(OP_REPLACE, 16'h1234, 1'b0, 1'b0);
        check_all("repl_empty", 16'h1234, 1, 1'b0, 1'b0);
        step(OP_PUSH, 16'hBEEF, 1'b0, 1'b0);
        step(OP_REPLACE, 16'hCAFE, 1'b0, 1'b0);
        step(OP_POP, 16'h0, 1'b0, 1'b0);
        check_all("repl_keep", 16'h1234, 1, 1'b0, 1'b0);

        // Reset beats a push in the same cycle
        step(OP_PUSH, 16'h00FF, 1'b0, 1'b0);
        step(OP_PUSH, 16'h0F0F, 1'b0, 1'b1);
        check_all("rst_prio", 16'h0000, 0, 1'b0, 1'b0);
        // Stale RAM words must not reappear after reset
        step(OP_PUSH, 16'h7777, 1'b0, 1'b0);
        step(OP_POP, 16'h0, 1'b0, 1'b0);
        check_all("stale", 16'h0000, 0, 1'b0, 1'b0);

        // Alternating PUSH/POP against a LIFO model, preloaded so POP reaches RAM
        model_q.delete();
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom);
            step(OP_PUSH, v, 1'b0, 1'b0);
            model_q.push_back(v);
        end
        for (int i = 0; i < 100; i++) begin
            v = 16'($urandom);
            step(OP_PUSH, v, 1'b0, 1'b0);
            model_q.push_back(v);
            check("alt.push.next", 32'(bus.next_out), 32'(model_q[$]));
            check("alt.push.count", 32'(bus.count), 32'(model_q.size()));
            step(OP_POP, 16'h0, 1'b0, 1'b0);
            void'(model_q.pop_back());
            check("alt.pop.next", 32'(bus.next_out), 32'(model_q.size() > 0 ? model_q[$] : 16'h0));
            check("alt.pop.count", 32'(bus.count), 32'(model_q.size()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_stack.md
DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 Parameter DATA_W, default 16, data word width; matches every Y-path operand.
REQ-002 Parameter DEPTH, default 16, number of spill-RAM entries below the NEXT register.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 op  input  2  stack operation: 00 HOLD, 01 PUSH, 10 POP, 11 REPLACE.
REQ-006 din  input  DATA_W  value written into NEXT on PUSH/REPLACE (the current TOS).
REQ-007 clr_err  input  1  clears sticky error flags.
REQ-008 next_out  output  DATA_W  registered NEXT value; drives the yN input of the Y mux.
REQ-009 count  output  clog2(DEPTH+2)  number of valid elements, NEXT included, range 0..DEPTH+1.
REQ-010 empty  output  1  high when count == 0.
REQ-011 full  output  1  high when count == DEPTH+1.
REQ-012 overflow  output  1  sticky; PUSH attempted while full.
REQ-013 underflow  output  1  sticky; POP attempted while empty.

Function
REQ-014 All outputs SHALL be registered or decoded from registered state only; an op presented at edge k is visible on outputs after edge k.
REQ-015 HOLD SHALL leave all state unchanged.
REQ-016 PUSH, not full: RAM[sp] <= next_out if count >= 1; next_out <= din; count += 1; sp += 1 only if count was >= 1.
REQ-017 POP, not empty: next_out <= RAM[sp-1] if count >= 2, else next_out <= 0; count -= 1; sp -= 1 only if count was >= 2.
REQ-018 REPLACE SHALL load next_out <= din without changing count or sp; on empty it behaves as PUSH (count becomes 1).
REQ-019 PUSH while full SHALL change no data, count or sp, and SHALL set overflow.
REQ-020 POP while empty SHALL keep next_out = 0 and count = 0, and SHALL set underflow.
REQ-021 sp SHALL never wrap; it stays within 0..DEPTH.
REQ-022 RAM read for POP SHALL be combinational from the register file, giving single-cycle POP with no bubble.
REQ-023 Back-to-back ops on consecutive cycles SHALL be supported at full rate, including PUSH then POP of the same word.
REQ-024 clr_err SHALL clear overflow and underflow on the next edge; if an error event occurs in the same cycle, the set wins.
REQ-025 RAM contents at or above sp are don't-care and SHALL never reach next_out.

Reset
REQ-026 On rst high at an edge: next_out = 0, count = 0, sp = 0, overflow = 0, underflow = 0. RAM is not cleared.
REQ-027 rst SHALL take priority over op and clr_err in the same cycle; an operation in flight is discarded.

Structure
REQ-028 The op encodings (HOLD/PUSH/POP/REPLACE) and DATA_W SHALL live in the shared package asterix_pkg, which the ALU and the Y/T multiplexers use.
REQ-029 The spill storage SHALL be a sub-module stack_ram with one synchronous write port and one combinational read port, DEPTH x DATA_W.
REQ-030 Control (sp, count, flags, next register) SHALL stay in data_stack.

Verification
REQ-031 Reset then PUSH 0x1111, 0x2222, 0x3333 -> next_out 0x3333, count 3; POP x3 -> next_out 0x2222, 0x1111, 0x0000, count 0, no flags.
REQ-032 Fill with DEPTH+1 PUSHes of 0x0001..0x0011 -> full = 1; one more PUSH 0xFFFF -> overflow = 1, next_out stays 0x0011, count stays 17.
REQ-033 POP on empty stack -> underflow = 1, next_out 0x0000, count 0; clr_err -> underflow 0 next cycle.
REQ-034 PUSH 0xAAAA, REPLACE 0x5555, POP -> next_out 0x5555 then 0x0000; REPLACE on empty with 0x1234 -> count 1, next_out 0x1234.
REQ-035 PUSH 0x00FF, then rst asserted the same cycle as a PUSH 0x0F0F -> all outputs reset values, count 0.
REQ-036 Alternating PUSH/POP every cycle for 100 random values against a reference LIFO model -> next_out and count match every cycle.
